updown_cnt_n: RTL and testbench
===============================

Name: updown_cnt_n

Overview:
- Parametrised up/down counter; successor to the 8-bit start/stop up counter.
- Adds:
  - configurable width and modulus;
  - count direction;
  - parallel load;
  - wrap, saturate or one-shot terminal behaviour;
  - a start/stop run-control FSM.
- Used as a general event/timer counter by chap_5 and later datapath blocks.
- Fully synchronous to a single clock edge. No level-sensitive updates.

Parameters:
- WIDTH, 8, counter width in bits (1..32).
- MAX_VAL, 2**WIDTH-1, terminal value for up-count and reload value for down-wrap. Legal range 1..2**WIDTH-1.
- MODE, CNT_WRAP, terminal behaviour: CNT_WRAP, CNT_SAT or CNT_ONESHOT (from package).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request: IDLE/DONE -> RUN.
- stop  in  1  one-cycle request: RUN -> IDLE. count is held.
- en  in  1  count enable. Effective only in RUN.
- up_dn  in  1  1 = count up, 0 = count down. Sampled every enabled cycle.
- load  in  1  parallel load request.
- load_val  in  WIDTH  value to load. Clamped to MAX_VAL.
- count  out  WIDTH  registered counter value.
- tc  out  1  registered one-cycle pulse: a terminal event occurred on the previous edge.
- busy  out  1  state == RUN.
- done  out  1  state == DONE. Used only when MODE = CNT_ONESHOT; otherwise constant 0.

Behaviour:
- Reset (rst=1 at an edge): count=0, state=IDLE, tc=0, busy=0, done=0. rst overrides all other inputs.
- FSM states and transitions:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE. In ONESHOT, a terminal event -> DONE.
  - DONE: start -> RUN, and count reloads to 0 (up_dn=1) or MAX_VAL (up_dn=0) on the same edge. load is also accepted in DONE.
- Per-edge priority: rst > load > stop > start > count step.
- Load:
  - count <= min(load_val, MAX_VAL) in any state.
  - State is unchanged. No tc pulse.
  - A start in the same cycle is ignored.
- Count step: only when state=RUN && en=1 && no load/stop.
- Up-count:
  - count < MAX_VAL: count+1.
  - count == MAX_VAL: terminal event.
- Down-count:
  - count > 0: count-1.
  - count == 0: terminal event.
- Terminal event by MODE:
  - WRAP: up -> 0, down -> MAX_VAL.
  - SAT: count holds.
  - ONESHOT: count holds; state -> DONE.
- tc:
  - Asserted for exactly one cycle after each terminal event.
  - In SAT, it pulses on every enabled cycle spent at the limit.
- Latency: count reflects an enabled step one clock after the edge where en is sampled. busy/done/tc are registered, aligned with count.
- start while already in RUN: no effect.
- stop while in IDLE or DONE: no effect.
- Direction change mid-run takes effect on the next enabled step, with no extra cycle.
- count > MAX_VAL is unreachable: load clamps and reset is 0.
- All arithmetic is WIDTH bits, with no carry out. MAX_VAL = 2**WIDTH-1 must wrap naturally with no overflow warnings.
- rst mid-RUN or mid-DONE returns to IDLE on that edge; any pending tc is cleared.

Decomposition:
- Package cnt_pkg:
  - MODE encodings CNT_WRAP=0, CNT_SAT=1, CNT_ONESHOT=2;
  - FSM state encoding ST_IDLE, ST_RUN, ST_DONE (2 bits).
- One natural sub-module, cnt_next_val: combinational next-count and terminal-detect from count, up_dn, MAX_VAL and MODE.
- The FSM, load path and output registers stay in updown_cnt_n.

Test Plan:
- Reset, then start, en=1, up_dn=1, WIDTH=4, MAX_VAL=9, WRAP:
  - count 0,1,...,9,0;
  - tc high for exactly the cycle count=0 follows 9;
  - busy=1 throughout.
- Down-count, WRAP, MAX_VAL=9:
  - load_val=2, then run with up_dn=0: count 2,1,0,9;
  - tc pulses once, after the 0->9 edge.
- SAT, up, MAX_VAL=5, en held 3 cycles at the limit: count stays 5 and tc pulses every one of those cycles.
- ONESHOT, up, MAX_VAL=3:
  - count 0..3, then busy=0, done=1, count holds 3;
  - start with up_dn=0: count=3 (reload MAX_VAL), busy=1, done=0.
- Priority:
  - load=1, load_val=12 (>MAX_VAL=9) with stop=1 and en=1 in the same cycle: count=9 and state stays RUN.
  - Next cycle stop alone: busy=0 and count holds 9.
- Synchronous reset: rst=1 mid-RUN at count=6: on the next edge count=0, busy=0, tc=0. While rst is high, start is ignored.

Source files
------------

// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared encodings for the up/down counter family
package cnt_pkg;

    // Terminal behaviour when the count reaches its limit
    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2
    } cnt_mode_e;

    // Run-control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/cnt_next_val.sv
// rtl/cnt_next_val.sv - combinational next-count and terminal detect
module cnt_next_val
    import cnt_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter cnt_mode_e        MODE    = CNT_WRAP
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up_dn,
    output logic [WIDTH-1:0] o_next,
    output logic             o_terminal
);

    logic w_at_max;
    logic w_at_zero;

    assign w_at_max  = (i_count == MAX_VAL);
    assign w_at_zero = (i_count == '0);

    // Step away from the limit, or apply the mode's terminal rule at it
    always_comb begin
        o_terminal = i_up_dn ? w_at_max : w_at_zero;
        o_next     = i_count;
        if (!o_terminal) begin
            // WIDTH-bit arithmetic; no carry is ever needed away from the limits
            o_next = i_up_dn ? (i_count + WIDTH'(1)) : (i_count - WIDTH'(1));
        end else if (MODE == CNT_WRAP) begin
            o_next = i_up_dn ? '0 : MAX_VAL;
        end
    end

endmodule

// File: rtl/updown_cnt_n.sv
// rtl/updown_cnt_n.sv - parametrised up/down counter with run-control FSM
module updown_cnt_n
    import cnt_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter cnt_mode_e        MODE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    cnt_state_e       r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_next;
    logic             w_terminal;
    logic [WIDTH-1:0] w_load_clamped;

    // Extra zero bit keeps the compare meaningful when MAX_VAL is all ones
    assign w_load_clamped = ({1'b0, load_val} > {1'b0, MAX_VAL}) ? MAX_VAL : load_val;

    cnt_next_val #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .MODE    (MODE)
    ) u_next (
        .i_count    (r_count),
        .i_up_dn    (up_dn),
        .o_next     (w_next),
        .o_terminal (w_terminal)
    );

    // Run-control FSM, load path and registered outputs; priority rst > load > stop > start > step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_state <= ST_IDLE;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (load) begin
                r_count <= w_load_clamped;
            end else if (stop && (r_state == ST_RUN)) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else if (start && (r_state != ST_RUN)) begin
                // Restart from DONE begins again from the end matching the direction
                if (r_state == ST_DONE) begin
                    r_count <= up_dn ? '0 : MAX_VAL;
                end
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
            end else if ((r_state == ST_RUN) && en) begin
                r_count <= w_next;
                if (w_terminal) begin
                    r_tc <= 1'b1;
                    if (MODE == CNT_ONESHOT) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_updown_cnt_n.sv
// tb/tb_updown_cnt_n.sv - self-checking bench for updown_cnt_n
module tb_updown_cnt_n;
    import cnt_pkg::*;

    localparam int NDUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, stop, en, up_dn, load;
    logic [7:0] load_val;
    logic [3:0] count0, count1, count2;
    logic [7:0] count3;
    logic [NDUT-1:0] tc, busy, done;

    updown_cnt_n #(.WIDTH(4), .MAX_VAL(4'd9), .MODE(CNT_WRAP)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val[3:0]), .count(count0), .tc(tc[0]), .busy(busy[0]), .done(done[0]));
    updown_cnt_n #(.WIDTH(4), .MAX_VAL(4'd5), .MODE(CNT_SAT)) u_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val[3:0]), .count(count1), .tc(tc[1]), .busy(busy[1]), .done(done[1]));
    updown_cnt_n #(.WIDTH(4), .MAX_VAL(4'd3), .MODE(CNT_ONESHOT)) u_one (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val[3:0]), .count(count2), .tc(tc[2]), .busy(busy[2]), .done(done[2]));
    updown_cnt_n #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .count(count3), .tc(tc[3]), .busy(busy[3]), .done(done[3]));

    // Reference model: plain integers; st 0 = stopped, 1 = running, 2 = finished
    int max_v[NDUT]  = '{9, 5, 3, 255};
    int mode_v[NDUT] = '{0, 1, 2, 0};
    int mask_v[NDUT] = '{15, 15, 15, 255};
    int m_cnt[NDUT];
    int m_st[NDUT];
    int m_tc[NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dut_count(input int i);
        case (i)
            0:       return int'(count0);
            1:       return int'(count1);
            2:       return int'(count2);
            default: return int'(count3);
        endcase
    endfunction

    task automatic model_edge();
        int lv;
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_st[i] = 0; m_tc[i] = 0;
            end else begin
                m_tc[i] = 0;
                lv = int'(load_val) & mask_v[i];
                if (load) begin
                    m_cnt[i] = (lv > max_v[i]) ? max_v[i] : lv;
                end else if (stop && m_st[i] == 1) begin
                    m_st[i] = 0;
                end else if (start && m_st[i] != 1) begin
                    if (m_st[i] == 2) m_cnt[i] = up_dn ? 0 : max_v[i];
                    m_st[i] = 1;
                end else if (m_st[i] == 1 && en) begin
                    if (up_dn && m_cnt[i] < max_v[i]) begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end else if (!up_dn && m_cnt[i] > 0) begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end else begin
                        m_tc[i] = 1;
                        if (mode_v[i] == 0) m_cnt[i] = up_dn ? 0 : max_v[i];
                        if (mode_v[i] == 2) m_st[i] = 2;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("count[%0d]", i), dut_count(i), m_cnt[i]);
            check_eq($sformatf("tc[%0d]", i), int'(tc[i]), m_tc[i]);
            check_eq($sformatf("busy[%0d]", i), int'(busy[i]), (m_st[i] == 1) ? 1 : 0);
            check_eq($sformatf("done[%0d]", i), int'(done[i]), (m_st[i] == 2) ? 1 : 0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'd0;
        @(negedge clk);
        cycle();
        cycle();
        check_eq("reset_count", int'(count0), 0);
        check_eq("reset_busy", int'(busy[0]), 0);
        rst = 1'b0;

        // Up-count WRAP 0..9,0; ONESHOT reaches 3 and stops
        start = 1'b1; en = 1'b1; up_dn = 1'b1;
        cycle();
        check_eq("start_count", int'(count0), 0);
        check_eq("start_busy", int'(busy[0]), 1);
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            cycle();
            if (k == 9)  begin check_eq("up9_count", int'(count0), 9); check_eq("up9_tc", int'(tc[0]), 0); end
            if (k == 10) begin check_eq("wrap_count", int'(count0), 0); check_eq("wrap_tc", int'(tc[0]), 1); end
            if (k == 11) begin check_eq("after_wrap_tc", int'(tc[0]), 0); check_eq("busy_run", int'(busy[0]), 1); end
        end
        check_eq("oneshot_done", int'(done[2]), 1);
        check_eq("oneshot_busy", int'(busy[2]), 0);
        check_eq("oneshot_hold", int'(count2), 3);

        // Restart ONESHOT downward reloads MAX_VAL
        start = 1'b1; up_dn = 1'b0;
        cycle();
        check_eq("restart_count", int'(count2), 3);
        check_eq("restart_busy", int'(busy[2]), 1);
        check_eq("restart_done", int'(done[2]), 0);
        start = 1'b0;

        // Down WRAP from a loaded 2
        load = 1'b1; load_val = 8'd2; en = 1'b0;
        cycle();
        check_eq("load2", int'(count0), 2);
        load = 1'b0; en = 1'b1;
        cycle();
        cycle();
        check_eq("down0_count", int'(count0), 0);
        check_eq("down0_tc", int'(tc[0]), 0);
        cycle();
        check_eq("down_wrap_count", int'(count0), 9);
        check_eq("down_wrap_tc", int'(tc[0]), 1);

        // Priority: load beats stop and clamps
        load = 1'b1; load_val = 8'd4; en = 1'b0;
        cycle();
        load_val = 8'd12; stop = 1'b1; en = 1'b1;
        cycle();
        check_eq("clamp_count", int'(count0), 9);
        check_eq("load_keeps_run", int'(busy[0]), 1);
        load = 1'b0;
        cycle();
        check_eq("stop_busy", int'(busy[0]), 0);
        check_eq("stop_hold", int'(count0), 9);
        stop = 1'b0;

        // Reset mid-run at 6, start ignored during reset
        start = 1'b1; en = 1'b0;
        cycle();
        start = 1'b0; load = 1'b1; load_val = 8'd6;
        cycle();
        load = 1'b0; rst = 1'b1; start = 1'b1; en = 1'b1;
        cycle();
        check_eq("rst_count", int'(count0), 0);
        check_eq("rst_busy", int'(busy[0]), 0);
        check_eq("rst_tc", int'(tc[0]), 0);
        cycle();
        check_eq("rst_start_ignored", int'(busy[0]), 0);
        rst = 1'b0; start = 1'b0; en = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 800; n++) begin
            rst      = ($urandom_range(63) == 0);
            load     = ($urandom_range(15) == 0);
            stop     = ($urandom_range(15) == 0);
            start    = ($urandom_range(7) == 0);
            en       = ($urandom_range(3) != 0);
            up_dn    = ($urandom_range(3) != 0);
            load_val = 8'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
